uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//  Serial-to-parallel UART receiver, 8N1, LSB first, idle-high line.
//  Synchronises the asynchronous rx pin and validates the start bit at mid-bit.
//  Samples each data bit and the stop bit at mid-bit.
//  Presents the received byte with a one-cycle done strobe to the host logic
//  on the 50 MHz system clock.
// PARAMETERS
//  CYCLES_PER_BIT  434  bit period is CYCLES_PER_BIT+1 clocks (counter runs 0..CYCLES_PER_BIT)
//  HALF_BIT        217  counter value at which the start bit is re-checked (CYCLES_PER_BIT/2)
//  PAYLOAD_BITS    8    data bits per frame (1..8), LSB first
// PORTS
//  clk_50M    in   1  system clock, 50 MHz
//  rst        in   1  asynchronous reset, active-high
//  rx         in   1  serial input, asynchronous to clk_50M, idle high
//  rx_data    out  8  last correctly framed byte; bits above PAYLOAD_BITS-1 read 0
//  rx_done    out  1  one-cycle pulse: rx_data has just been updated
//  frame_err  out  1  one-cycle pulse: stop bit sampled low, frame discarded
//  rx_busy    out  1  high whenever state != IDLE
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE, cycle_count=0, bit index=0,
//   shift reg=0, rx_data=0, rx_done=0, frame_err=0, rx_busy=0, both sync flops=1.
//  Input sync: rx passes through 2 flops to give rx_s; all decisions use rx_s only.
//  FSM (11-bit cycle_count, 3-bit index):
//   IDLE:  cycle_count=0. rx_s==0 -> START.
//   START: count up. At cycle_count==HALF_BIT:
//          rx_s==0 -> cycle_count=0, index=0, go to DATA.
//          rx_s==1 -> false start, go to IDLE (no pulse).
//   DATA:  count up. At cycle_count==CYCLES_PER_BIT:
//          shift[index] <= rx_s and cycle_count=0.
//          If index==PAYLOAD_BITS-1, go to STOP; else index++.
//   STOP:  count up. At cycle_count==CYCLES_PER_BIT, sample rx_s:
//          1 -> rx_data<=shift, rx_done=1 for one clock.
//          0 -> frame_err=1 for one clock, rx_data unchanged.
//          Either way, go to IDLE the same clock.
//  Sampling point: start is checked mid-bit; each later sample falls one full
//   period after the previous one, so data and stop are sampled near mid-bit.
//  Latency: rx_done rises
//   2 + (HALF_BIT+1) + (PAYLOAD_BITS+1)*(CYCLES_PER_BIT+1) + 1 clocks
//   after rx falls at the pin (+/-1 for synchroniser phase).
//  Back-to-back frames: the FSM returns to IDLE at the stop-bit mid-point, so a
//   start edge is accepted in the second half of the stop bit (zero idle gap).
//  rx_done and frame_err are never high in the same cycle and never exceed 1 clock.
//  The line stuck low after a framing error restarts a frame only after rx_s is
//   seen low in IDLE. No break detection.
//  Reset mid-frame: the partial frame is dropped and no pulse is issued.
//   Reception resumes on the next falling edge after reset release.
//  Tolerance: correct reception with up to +/-3% baud mismatch.
// TESTING
//  1. Send 0xA5 at 435 clk/bit -> rx_done single pulse; rx_data=0xA5;
//     frame_err never high; rx_busy low after the pulse.
//  2. Drive rx low for 100 clocks then high -> no rx_done or frame_err;
//     FSM back in IDLE; rx_data keeps its prior value.
//  3. Send 0x3C, then a frame with the stop bit forced 0 ->
//     frame_err pulse on the second frame; rx_data stays 0x3C.
//  4. Send 0x00 then 0xFF with no idle gap -> two rx_done pulses
//     10*435 +/-2 clocks apart; values 0x00 then 0xFF.
//  5. Assert rst during data bit 4 of 0x96, release, then send 0x5A ->
//     outputs zero during reset; no pulse for the partial frame;
//     rx_data=0x5A with one rx_done.
//  6. Send 0x55 at 422 and 448 clk/bit (+/-3%) -> rx_data=0x55
//     with no frame_err.

Source files
------------

// File: rtl/uart_rx.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// uart_rx
//   Serial-to-parallel UART receiver, 8N1 framing, LSB first, idle-high line.
//   The asynchronous rx pin is brought into the clk_50M domain through two
//   flops. The start bit is re-checked at mid-bit, and each data bit and the
//   stop bit are sampled one full bit period after the previous sample.
//
// Ports
//   clk_50M    in   1  system clock
//   rst        in   1  asynchronous reset, active-high
//   rx         in   1  serial input, asynchronous, idle high
//   rx_data    out  8  last correctly framed byte (bits >= PAYLOAD_BITS are 0)
//   rx_done    out  1  one-cycle pulse when rx_data has just been updated
//   frame_err  out  1  one-cycle pulse when the stop bit was sampled low
//   rx_busy    out  1  high whenever the receiver is not idle
// ----------------------------------------------------------------------------
module uart_rx #(
    parameter int unsigned CYCLES_PER_BIT = 434,
    parameter int unsigned HALF_BIT       = 217,
    parameter int unsigned PAYLOAD_BITS   = 8
) (
    input  logic       clk_50M,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_done,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam logic [10:0] CNT_FULL = 11'(CYCLES_PER_BIT);
    localparam logic [10:0] CNT_HALF = 11'(HALF_BIT);
    localparam logic [2:0]  IDX_LAST = 3'(PAYLOAD_BITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } state_t;

    state_t      state_q,   state_d;
    logic [10:0] count_q,   count_d;
    logic [2:0]  index_q,   index_d;
    logic [7:0]  shift_q,   shift_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        done_q,    done_d;
    logic        ferr_q,    ferr_d;

    // Two-flop synchroniser; both stages reset to the idle (high) level so a
    // reset release never looks like a falling edge.
    logic rx_meta_q;
    logic rx_s_q;

    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            index_q   <= '0;
            shift_q   <= '0;
            rx_data_q <= '0;
            done_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            index_q   <= index_d;
            shift_q   <= shift_d;
            rx_data_q <= rx_data_d;
            done_q    <= done_d;
            ferr_q    <= ferr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        index_d   = index_q;
        shift_d   = shift_q;
        rx_data_d = rx_data_q;
        done_d    = 1'b0;
        ferr_d    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                count_d = '0;
                index_d = '0;
                if (!rx_s_q) begin
                    state_d = ST_START;
                end
            end

            ST_START: begin
                if (count_q == CNT_HALF) begin
                    count_d = '0;
                    if (!rx_s_q) begin
                        index_d = '0;
                        state_d = ST_DATA;
                    end else begin
                        // Glitch shorter than half a bit: silently drop it.
                        state_d = ST_IDLE;
                    end
                end else begin
                    count_d = count_q + 11'd1;
                end
            end

            ST_DATA: begin
                if (count_q == CNT_FULL) begin
                    count_d          = '0;
                    // index never exceeds IDX_LAST, so bits above the payload
                    // keep their reset value of zero.
                    shift_d[index_q] = rx_s_q;
                    if (index_q == IDX_LAST) begin
                        state_d = ST_STOP;
                    end else begin
                        index_d = index_q + 3'd1;
                    end
                end else begin
                    count_d = count_q + 11'd1;
                end
            end

            ST_STOP: begin
                if (count_q == CNT_FULL) begin
                    count_d = '0;
                    // Returning to idle at the stop-bit mid-point lets the next
                    // start edge arrive with no idle gap.
                    state_d = ST_IDLE;
                    if (rx_s_q) begin
                        rx_data_d = shift_q;
                        done_d    = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end else begin
                    count_d = count_q + 11'd1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign rx_data   = rx_data_q;
    assign rx_done   = done_q;
    assign frame_err = ferr_q;
    assign rx_busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// tb_uart_rx
//   Directed bench for uart_rx with default parameters (435 clocks per bit).
//   A negedge monitor counts rx_done / frame_err pulses and records their
//   timing; scenario tasks drive the line and compare against hand-computed
//   values.
// ----------------------------------------------------------------------------
module tb_uart_rx;

    logic       clk_50M = 1'b0;
    logic       rst     = 1'b1;
    logic       rx      = 1'b1;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       frame_err;
    logic       rx_busy;

    int tests = 0;
    int fails = 0;

    uart_rx #(
        .CYCLES_PER_BIT (434),
        .HALF_BIT       (217),
        .PAYLOAD_BITS   (8)
    ) dut (
        .clk_50M   (clk_50M),
        .rst       (rst),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_done   (rx_done),
        .frame_err (frame_err),
        .rx_busy   (rx_busy)
    );

    always #10 clk_50M = ~clk_50M;

    // Pulse monitor, sampled on the falling edge.
    int         cyc           = 0;
    int         done_cnt      = 0;
    int         ferr_cnt      = 0;
    int         overlap_cnt   = 0;
    int         wide_cnt      = 0;
    int         last_done_cyc = 0;
    int         prev_done_cyc = 0;
    logic [7:0] last_data     = 8'h00;
    logic [7:0] prev_data     = 8'h00;
    logic       prev_done     = 1'b0;
    logic       prev_ferr     = 1'b0;

    always @(negedge clk_50M) begin
        cyc = cyc + 1;
        if (rx_done === 1'b1) begin
            done_cnt      = done_cnt + 1;
            prev_done_cyc = last_done_cyc;
            last_done_cyc = cyc;
            prev_data     = last_data;
            last_data     = rx_data;
            if (prev_done) wide_cnt = wide_cnt + 1;
        end
        if (frame_err === 1'b1) begin
            ferr_cnt = ferr_cnt + 1;
            if (prev_ferr) wide_cnt = wide_cnt + 1;
        end
        if (rx_done === 1'b1 && frame_err === 1'b1) overlap_cnt = overlap_cnt + 1;
        prev_done = (rx_done === 1'b1);
        prev_ferr = (frame_err === 1'b1);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        fails = fails + 1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_50M);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input int cpb,
                              input logic stop_val, input int stop_len);
        rx = 1'b0;
        tick(cpb);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(cpb);
        end
        rx = stop_val;
        tick(stop_len);
        rx = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rx  = 1'b1;
        tick(5);
        tests++; if (rx_data !== 8'h00) begin fails++; $display("FAIL reset_data: got %h expected 00", rx_data); end
        tests++; if (rx_done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", rx_done); end
        tests++; if (frame_err !== 1'b0) begin fails++; $display("FAIL reset_ferr: got %b expected 0", frame_err); end
        tests++; if (rx_busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", rx_busy); end
        rst = 1'b0;
        tick(3);
        tests++; if (rx_busy !== 1'b0) begin fails++; $display("FAIL release_busy: got %b expected 0", rx_busy); end
        tick(20);
    endtask

    task automatic test_basic();
        int d0, f0, s;
        d0 = done_cnt;
        f0 = ferr_cnt;
        s  = cyc;
        send_frame(8'hA5, 435, 1'b1, 435);
        tick(10);
        tests++; if (done_cnt - d0 !== 1) begin fails++; $display("FAIL basic_done_count: got %0d expected 1", done_cnt - d0); end
        tests++; if (rx_data !== 8'hA5) begin fails++; $display("FAIL basic_data: got %h expected a5", rx_data); end
        tests++; if (ferr_cnt - f0 !== 0) begin fails++; $display("FAIL basic_ferr: got %0d expected 0", ferr_cnt - f0); end
        tests++; if (rx_busy !== 1'b0) begin fails++; $display("FAIL basic_busy: got %b expected 0", rx_busy); end
        // Start edge to rx_done: 2 + 218 + 9*435 + 1 = 4136 clocks (+/-1 sync phase).
        tests++;
        if (last_done_cyc - s < 4135 || last_done_cyc - s > 4138) begin
            fails++;
            $display("FAIL basic_latency: got %0d expected 4135..4138", last_done_cyc - s);
        end
    endtask

    task automatic test_false_start();
        int d0, f0;
        d0 = done_cnt;
        f0 = ferr_cnt;
        rx = 1'b0;
        tick(50);
        tests++; if (rx_busy !== 1'b1) begin fails++; $display("FAIL false_busy_high: got %b expected 1", rx_busy); end
        tick(50);
        rx = 1'b1;
        tick(300);
        tests++; if (rx_busy !== 1'b0) begin fails++; $display("FAIL false_busy_idle: got %b expected 0", rx_busy); end
        tests++; if (done_cnt - d0 !== 0) begin fails++; $display("FAIL false_done: got %0d expected 0", done_cnt - d0); end
        tests++; if (ferr_cnt - f0 !== 0) begin fails++; $display("FAIL false_ferr: got %0d expected 0", ferr_cnt - f0); end
        tests++; if (rx_data !== 8'hA5) begin fails++; $display("FAIL false_data: got %h expected a5", rx_data); end
    endtask

    task automatic test_frame_error();
        int d0, f0;
        d0 = done_cnt;
        f0 = ferr_cnt;
        send_frame(8'h3C, 435, 1'b1, 435);
        tick(10);
        tests++; if (rx_data !== 8'h3C) begin fails++; $display("FAIL ferr_first_data: got %h expected 3c", rx_data); end
        // Stop bit held low past the sample point, then the line recovers.
        send_frame(8'h81, 435, 1'b0, 300);
        tick(800);
        tests++; if (ferr_cnt - f0 !== 1) begin fails++; $display("FAIL ferr_count: got %0d expected 1", ferr_cnt - f0); end
        tests++; if (done_cnt - d0 !== 1) begin fails++; $display("FAIL ferr_done_count: got %0d expected 1", done_cnt - d0); end
        tests++; if (rx_data !== 8'h3C) begin fails++; $display("FAIL ferr_data_kept: got %h expected 3c", rx_data); end
        tests++; if (rx_busy !== 1'b0) begin fails++; $display("FAIL ferr_busy: got %b expected 0", rx_busy); end
    endtask

    task automatic test_back_to_back();
        int d0, gap;
        d0 = done_cnt;
        send_frame(8'h00, 435, 1'b1, 435);
        send_frame(8'hFF, 435, 1'b1, 435);
        tick(10);
        gap = last_done_cyc - prev_done_cyc;
        tests++; if (done_cnt - d0 !== 2) begin fails++; $display("FAIL b2b_count: got %0d expected 2", done_cnt - d0); end
        tests++; if (prev_data !== 8'h00) begin fails++; $display("FAIL b2b_first: got %h expected 00", prev_data); end
        tests++; if (last_data !== 8'hFF) begin fails++; $display("FAIL b2b_second: got %h expected ff", last_data); end
        tests++;
        if (gap < 4348 || gap > 4352) begin
            fails++;
            $display("FAIL b2b_gap: got %0d expected 4348..4352", gap);
        end
    endtask

    task automatic test_reset_midframe();
        int d0, f0;
        logic [7:0] b;
        b  = 8'h96;
        rx = 1'b0;
        tick(435);
        for (int i = 0; i < 4; i++) begin
            rx = b[i];
            tick(435);
        end
        rx = b[4];
        tick(200);
        tests++; if (rx_busy !== 1'b1) begin fails++; $display("FAIL mid_busy: got %b expected 1", rx_busy); end
        d0  = done_cnt;
        f0  = ferr_cnt;
        rst = 1'b1;
        tick(2);
        tests++; if (rx_data !== 8'h00) begin fails++; $display("FAIL mid_rst_data: got %h expected 00", rx_data); end
        tests++; if (rx_done !== 1'b0) begin fails++; $display("FAIL mid_rst_done: got %b expected 0", rx_done); end
        tests++; if (frame_err !== 1'b0) begin fails++; $display("FAIL mid_rst_ferr: got %b expected 0", frame_err); end
        tests++; if (rx_busy !== 1'b0) begin fails++; $display("FAIL mid_rst_busy: got %b expected 0", rx_busy); end
        rx = 1'b1;
        tick(10);
        rst = 1'b0;
        tick(1000);
        tests++; if (done_cnt - d0 !== 0) begin fails++; $display("FAIL mid_no_done: got %0d expected 0", done_cnt - d0); end
        tests++; if (ferr_cnt - f0 !== 0) begin fails++; $display("FAIL mid_no_ferr: got %0d expected 0", ferr_cnt - f0); end
        send_frame(8'h5A, 435, 1'b1, 435);
        tick(10);
        tests++; if (done_cnt - d0 !== 1) begin fails++; $display("FAIL mid_resume_count: got %0d expected 1", done_cnt - d0); end
        tests++; if (rx_data !== 8'h5A) begin fails++; $display("FAIL mid_resume_data: got %h expected 5a", rx_data); end
    endtask

    task automatic test_baud_tolerance();
        int d0, f0;
        d0 = done_cnt;
        f0 = ferr_cnt;
        send_frame(8'h55, 422, 1'b1, 422);
        tick(20);
        tests++; if (done_cnt - d0 !== 1) begin fails++; $display("FAIL fast_count: got %0d expected 1", done_cnt - d0); end
        tests++; if (rx_data !== 8'h55) begin fails++; $display("FAIL fast_data: got %h expected 55", rx_data); end
        // Overwrite with a different byte so the slow case must really update rx_data.
        send_frame(8'hC3, 435, 1'b1, 435);
        tick(20);
        send_frame(8'h55, 448, 1'b1, 448);
        tick(20);
        tests++; if (done_cnt - d0 !== 3) begin fails++; $display("FAIL slow_count: got %0d expected 3", done_cnt - d0); end
        tests++; if (rx_data !== 8'h55) begin fails++; $display("FAIL slow_data: got %h expected 55", rx_data); end
        tests++; if (ferr_cnt - f0 !== 0) begin fails++; $display("FAIL tol_ferr: got %0d expected 0", ferr_cnt - f0); end
    endtask

    task automatic test_pulse_props();
        tests++; if (overlap_cnt !== 0) begin fails++; $display("FAIL pulse_overlap: got %0d expected 0", overlap_cnt); end
        tests++; if (wide_cnt !== 0) begin fails++; $display("FAIL pulse_width: got %0d expected 0", wide_cnt); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_false_start();
        test_frame_error();
        test_back_to_back();
        test_reset_midframe();
        test_baud_tolerance();
        test_pulse_props();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
